id_stage_pipe: RTL and testbench

Parametrised successor to the combinational decode stage. It decodes the logic, shift and immediate MIPS subset and forwards operands from NFWD write-back sources. It detects load-use hazards and registers the result into the ID/EX pipeline register with stall and flush control. It sits between the IF/ID register and the execute stage, drives the register-file read ports combinationally, and keeps a saturating stall counter.

---
 rtl/id_pkg.sv | 112 +++++++++++
 rtl/id_fwd_mux.sv | 24 ++
 rtl/id_stage_pipe.sv | 148 ++++++++++++++
 tb/tb_id_stage_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: ALU/opcode constants, decoded-control struct and the instruction decoder
// shared by the decode-stage pipeline.
package id_pkg;
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_AND = 8'h24;
    localparam logic [7:0] ALU_OR  = 8'h25;
    localparam logic [7:0] ALU_XOR = 8'h26;
    localparam logic [7:0] ALU_NOR = 8'h27;
    localparam logic [7:0] ALU_SLL = 8'h7C;
    localparam logic [7:0] ALU_SRL = 8'h02;
    localparam logic [7:0] ALU_SRA = 8'h03;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'd0,
        SEL_LOGIC = 3'd1,
        SEL_SHIFT = 3'd2
    } alu_sel_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_PREF    = 6'h33;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_SYNC = 6'h0F;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_NOR  = 6'h27;

    typedef struct packed {
        logic [7:0]  alu_op;
        alu_sel_e    alu_sel;
        logic        rd1_en;
        logic        rd2_en;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    // funct[1:0] selects the shift kind for both the shamt and the variable forms
    function automatic logic [7:0] shift_op(input logic [1:0] f);
        return f == 2'b00 ? ALU_SLL : f == 2'b10 ? ALU_SRL : ALU_SRA;
    endfunction

    function automatic ctrl_t decode(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] sh;
        ctrl_t c;
        op = ins[31:26];
        rt = ins[20:16];
        rd = ins[15:11];
        sh = ins[10:6];
        fn = ins[5:0];
        c = '0;
        c.alu_sel = SEL_NOP;
        c.illegal = 1'b1;
        if (op == OP_SPECIAL && sh == 5'd0 && fn >= FN_AND && fn <= FN_NOR) begin
            c.alu_op  = {2'b00, fn};
            c.alu_sel = SEL_LOGIC;
            c.rd1_en  = 1'b1;
            c.rd2_en  = 1'b1;
            c.wr_en   = 1'b1;
            c.wr_addr = rd;
            c.illegal = 1'b0;
        end else if (op == OP_SPECIAL && sh == 5'd0 &&
                     (fn == FN_SLLV || fn == FN_SRLV || fn == FN_SRAV)) begin
            c.alu_op  = shift_op(fn[1:0]);
            c.alu_sel = SEL_SHIFT;
            c.rd1_en  = 1'b1;
            c.rd2_en  = 1'b1;
            c.wr_en   = 1'b1;
            c.wr_addr = rd;
            c.illegal = 1'b0;
        end else if (ins[31:21] == 11'd0 && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)) begin
            c.alu_op  = shift_op(fn[1:0]);
            c.alu_sel = SEL_SHIFT;
            c.rd2_en  = 1'b1;
            c.wr_en   = 1'b1;
            c.wr_addr = rd;
            c.imm     = {27'd0, sh};
            c.illegal = 1'b0;
        end else if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
            c.alu_op  = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_XOR;
            c.alu_sel = SEL_LOGIC;
            c.rd1_en  = 1'b1;
            c.wr_en   = 1'b1;
            c.wr_addr = rt;
            c.imm     = {16'd0, ins[15:0]};
            c.illegal = 1'b0;
        end else if (op == OP_LUI) begin
            c.alu_op  = ALU_OR;
            c.alu_sel = SEL_LOGIC;
            c.wr_en   = 1'b1;
            c.wr_addr = rt;
            c.imm     = {ins[15:0], 16'd0};
            c.illegal = 1'b0;
        end else if ((op == OP_SPECIAL && fn == FN_SYNC) || op == OP_PREF) begin
            c.illegal = 1'b0;
        end
        return c;
    endfunction
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: per-read-port operand select; lowest-index forwarding hit wins,
// then register-file data (r0 reads zero), or the immediate when the port is unused.
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NFWD = 2
) (
    input  logic                 en,
    input  logic [4:0]           addr,
    input  logic [DW-1:0]        rf_data,
    input  logic [DW-1:0]        imm,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [DW*NFWD-1:0]   fwd_data,
    output logic [DW-1:0]        data
);
    always_comb begin
        data = !en ? imm : addr == 5'd0 ? '0 : rf_data;
        for (int i = NFWD - 1; i >= 0; i--)
            if (en && addr != 5'd0 && fwd_en[i] && fwd_addr[5*i +: 5] == addr)
                data = fwd_data[DW*i +: DW];
    end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, operand forwarding and load-use detection feeding the
// ID/EX register, with stall/flush control and a saturating bubble counter.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [31:0]          pc,
    input  logic [31:0]          ins,
    input  logic [DW-1:0]        rf_data1,
    input  logic [DW-1:0]        rf_data2,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [DW*NFWD-1:0]   fwd_data,
    input  logic                 ex_is_load,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 rd1_en,
    output logic                 rd2_en,
    output logic [4:0]           addr1,
    output logic [4:0]           addr2,
    output logic                 stall_req,
    output logic                 ex_valid,
    output logic [31:0]          ex_pc,
    output logic [7:0]           ex_alu_op,
    output logic [2:0]           ex_alu_sel,
    output logic [DW-1:0]        ex_src1,
    output logic [DW-1:0]        ex_src2,
    output logic [4:0]           ex_wr_addr,
    output logic                 ex_wr_en,
    output logic                 ex_illegal,
    output logic [CNTW-1:0]      stall_cnt
);
    ctrl_t ctrl;
    logic [DW-1:0] imm1, imm2, src1, src2;
    logic hazard;

    logic            ex_valid_q, ex_valid_d, ex_wr_en_q, ex_wr_en_d, ex_illegal_q, ex_illegal_d;
    logic [31:0]     ex_pc_q, ex_pc_d;
    logic [7:0]      ex_alu_op_q, ex_alu_op_d;
    logic [2:0]      ex_alu_sel_q, ex_alu_sel_d;
    logic [DW-1:0]   ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
    logic [4:0]      ex_wr_addr_q, ex_wr_addr_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    assign ctrl   = decode(ins);
    assign rd1_en = ctrl.rd1_en;
    assign rd2_en = ctrl.rd2_en;
    assign addr1  = ins[25:21];
    assign addr2  = ins[20:16];
    // port 2 only sees the immediate when port 1 is reading (I-type); LUI puts it on port 1
    assign imm1   = DW'(ctrl.imm);
    assign imm2   = ctrl.rd1_en ? imm1 : '0;

    id_fwd_mux #(.DW(DW), .NFWD(NFWD)) u_mux1 (
        .en(rd1_en), .addr(addr1), .rf_data(rf_data1), .imm(imm1),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(src1)
    );

    id_fwd_mux #(.DW(DW), .NFWD(NFWD)) u_mux2 (
        .en(rd2_en), .addr(addr2), .rf_data(rf_data2), .imm(imm2),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(src2)
    );

    assign hazard = in_valid && ex_is_load && fwd_en[0] && fwd_addr[4:0] != 5'd0 &&
                    ((rd1_en && fwd_addr[4:0] == addr1) || (rd2_en && fwd_addr[4:0] == addr2));
    assign stall_req = hazard || stall_in;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_alu_op_d  = ex_alu_op_q;
        ex_alu_sel_d = ex_alu_sel_q;
        ex_src1_d    = ex_src1_q;
        ex_src2_d    = ex_src2_q;
        ex_wr_addr_d = ex_wr_addr_q;
        ex_wr_en_d   = ex_wr_en_q;
        ex_illegal_d = ex_illegal_q;
        stall_cnt_d  = stall_cnt_q;
        if (!stall_in) begin
            if (flush || !in_valid || hazard) begin
                ex_valid_d   = 1'b0;
                ex_pc_d      = '0;
                ex_alu_op_d  = '0;
                ex_alu_sel_d = '0;
                ex_src1_d    = '0;
                ex_src2_d    = '0;
                ex_wr_addr_d = '0;
                ex_wr_en_d   = 1'b0;
                ex_illegal_d = 1'b0;
                if (!flush && hazard)
                    stall_cnt_d = stall_cnt_q == '1 ? stall_cnt_q : stall_cnt_q + CNTW'(1);
            end else begin
                ex_valid_d   = 1'b1;
                ex_pc_d      = pc;
                ex_alu_op_d  = ctrl.alu_op;
                ex_alu_sel_d = ctrl.alu_sel;
                ex_src1_d    = src1;
                ex_src2_d    = src2;
                ex_wr_addr_d = ctrl.wr_addr;
                ex_wr_en_d   = ctrl.wr_en;
                ex_illegal_d = ctrl.illegal;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_alu_op_q  <= '0;
            ex_alu_sel_q <= '0;
            ex_src1_q    <= '0;
            ex_src2_q    <= '0;
            ex_wr_addr_q <= '0;
            ex_wr_en_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_alu_sel_q <= ex_alu_sel_d;
            ex_src1_q    <= ex_src1_d;
            ex_src2_q    <= ex_src2_d;
            ex_wr_addr_q <= ex_wr_addr_d;
            ex_wr_en_q   <= ex_wr_en_d;
            ex_illegal_q <= ex_illegal_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_alu_op  = ex_alu_op_q;
    assign ex_alu_sel = ex_alu_sel_q;
    assign ex_src1    = ex_src1_q;
    assign ex_src2    = ex_src2_q;
    assign ex_wr_addr = ex_wr_addr_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign ex_illegal = ex_illegal_q;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus randomized traffic checked against
// an instruction-level reference model of the decode stage.
module tb_id_stage_pipe;
    localparam int DW = 32;
    localparam int NFWD = 2;
    localparam int CNTW = 4;

    logic clk = 1'b0;
    logic reset, in_valid, ex_is_load, stall_in, flush;
    logic [31:0] pc, ins;
    logic [DW-1:0] rf_data1, rf_data2;
    logic [NFWD-1:0] fwd_en;
    logic [5*NFWD-1:0] fwd_addr;
    logic [DW*NFWD-1:0] fwd_data;
    logic rd1_en, rd2_en, stall_req, ex_valid, ex_wr_en, ex_illegal;
    logic [4:0] addr1, addr2, ex_wr_addr;
    logic [31:0] ex_pc;
    logic [7:0] ex_alu_op;
    logic [2:0] ex_alu_sel;
    logic [DW-1:0] ex_src1, ex_src2;
    logic [CNTW-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail = 0;

    id_stage_pipe #(.DW(DW), .NFWD(NFWD), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .ins(ins),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .ex_is_load(ex_is_load), .stall_in(stall_in), .flush(flush),
        .rd1_en(rd1_en), .rd2_en(rd2_en), .addr1(addr1), .addr2(addr2), .stall_req(stall_req),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_alu_sel(ex_alu_sel),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_wr_addr(ex_wr_addr), .ex_wr_en(ex_wr_en),
        .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; pc = 0; ins = 0; rf_data1 = 0; rf_data2 = 0;
        fwd_en = 0; fwd_addr = 0; fwd_data = 0; ex_is_load = 0; stall_in = 0; flush = 0;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        logic [7:0] op; logic [2:0] sel; logic [31:0] s1, s2;
        logic [4:0] wa; logic we, ill, u1, u2;
    } ref_t;

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rfv);
        if (r == 0) return 0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_en[i] && fwd_addr[5*i +: 5] == r) return fwd_data[32*i +: 32];
        return rfv;
    endfunction

    function automatic logic [7:0] sh_code(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h04: return 8'h7C;
            6'h02, 6'h06: return 8'h02;
            default:      return 8'h03;
        endcase
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] w);
        logic [5:0] opc, fn;
        logic [4:0] rs, rt, rd, sh;
        ref_t e;
        opc = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
        e = '{op: 0, sel: 0, s1: 0, s2: 0, wa: 0, we: 0, ill: 1, u1: 0, u2: 0};
        if (opc == 0 && sh == 0 && fn inside {[6'h24:6'h27]})
            e = '{op: {2'b00, fn}, sel: 1, s1: opnd(rs, rf_data1), s2: opnd(rt, rf_data2), wa: rd, we: 1, ill: 0, u1: 1, u2: 1};
        else if (opc == 0 && sh == 0 && fn inside {6'h04, 6'h06, 6'h07})
            e = '{op: sh_code(fn), sel: 2, s1: opnd(rs, rf_data1), s2: opnd(rt, rf_data2), wa: rd, we: 1, ill: 0, u1: 1, u2: 1};
        else if (w[31:21] == 0 && fn inside {6'h00, 6'h02, 6'h03})
            e = '{op: sh_code(fn), sel: 2, s1: {27'd0, sh}, s2: opnd(rt, rf_data2), wa: rd, we: 1, ill: 0, u1: 0, u2: 1};
        else if (opc inside {6'h0C, 6'h0D, 6'h0E})
            e = '{op: 8'h24 + 8'(opc - 6'h0C), sel: 1, s1: opnd(rs, rf_data1), s2: {16'd0, w[15:0]}, wa: rt, we: 1, ill: 0, u1: 1, u2: 0};
        else if (opc == 6'h0F)
            e = '{op: 8'h25, sel: 1, s1: {w[15:0], 16'd0}, s2: 0, wa: rt, we: 1, ill: 0, u1: 0, u2: 0};
        else if ((opc == 0 && fn == 6'h0F) || opc == 6'h33)
            e.ill = 0;
        return e;
    endfunction

    task automatic test_reset();
        idle(); reset = 1;
        tick(); tick();
        n_tests++;
        if ({ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_wr_addr, ex_wr_en, ex_illegal, stall_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_idle: outputs not zero (valid=%b cnt=%0d pc=%h)", ex_valid, stall_cnt, ex_pc);
        end
        reset = 0;
        in_valid = 1; ins = i_ins(6'h0E, 5'd1, 5'd4, 16'h1);
        ex_is_load = 1; fwd_en = 2'b01; fwd_addr = {5'd0, 5'd1};
        repeat (5) tick();
        ex_is_load = 0; fwd_en = 0; ins = i_ins(6'h0D, 5'd1, 5'd2, 16'h1); rf_data1 = 7; pc = 32'h100;
        tick();
        n_tests++;
        if (ex_valid !== 1'b1 || stall_cnt !== 4'd5) begin
            n_fail++; $display("FAIL reset_pre: valid=%b cnt=%0d, expected 1 and 5", ex_valid, stall_cnt);
        end
        ex_is_load = 1; fwd_en = 2'b01; ins = i_ins(6'h0E, 5'd1, 5'd4, 16'h1);
        #2 reset = 1;
        #1;
        n_tests++;
        if ({ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_wr_addr, ex_wr_en, ex_illegal, stall_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_async: valid=%b cnt=%0d pc=%h, expected all zero", ex_valid, stall_cnt, ex_pc);
        end
        n_tests++;
        if (stall_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall_req: got %b expected 1", stall_req);
        end
        tick();
        reset = 0;
        idle();
    endtask

    task automatic test_ori();
        idle();
        in_valid = 1; pc = 32'h400; ins = i_ins(6'h0D, 5'd1, 5'd2, 16'h00FF);
        rf_data1 = 32'h1200; rf_data2 = 32'hDEAD;
        #1;
        n_tests++;
        if ({rd1_en, rd2_en, addr1, addr2} !== {1'b1, 1'b0, 5'd1, 5'd2}) begin
            n_fail++; $display("FAIL ori_rd_ports: rd1=%b rd2=%b a1=%0d a2=%0d expected 1 0 1 2", rd1_en, rd2_en, addr1, addr2);
        end
        tick();
        n_tests++;
        if (ex_src1 !== 32'h1200 || ex_src2 !== 32'h00FF) begin
            n_fail++; $display("FAIL ori_src: got %h %h expected 00001200 000000ff", ex_src1, ex_src2);
        end
        n_tests++;
        if ({ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_wr_addr, ex_wr_en, ex_illegal} !== {1'b1, 32'h400, 8'h25, 3'd1, 5'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL ori_ctrl: v=%b pc=%h op=%h sel=%0d wa=%0d we=%b ill=%b", ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_wr_addr, ex_wr_en, ex_illegal);
        end
    endtask

    task automatic test_fwd_priority();
        idle();
        in_valid = 1; ins = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
        rf_data1 = 32'h111; rf_data2 = 32'h222;
        fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hB, 32'hA};
        tick();
        n_tests++;
        if (ex_src1 !== 32'hA || ex_src2 !== 32'h222) begin
            n_fail++; $display("FAIL fwd_ex_priority: got %h %h expected a 222", ex_src1, ex_src2);
        end
        fwd_addr = {5'd2, 5'd1}; fwd_data = {32'hC, 32'hA};
        tick();
        n_tests++;
        if (ex_src1 !== 32'hA || ex_src2 !== 32'hC) begin
            n_fail++; $display("FAIL fwd_two_sources: got %h %h expected a c", ex_src1, ex_src2);
        end
        ins = r_ins(5'd0, 5'd2, 5'd3, 5'd0, 6'h24); fwd_addr = {5'd2, 5'd0};
        tick();
        n_tests++;
        if (ex_src1 !== 32'h0 || ex_src2 !== 32'hC) begin
            n_fail++; $display("FAIL fwd_r0_zero: got %h %h expected 0 c", ex_src1, ex_src2);
        end
    endtask

    task automatic test_load_use();
        idle();
        tick();
        in_valid = 1; ins = i_ins(6'h0E, 5'd1, 5'd4, 16'h1); rf_data1 = 32'h99;
        ex_is_load = 1; fwd_en = 2'b01; fwd_addr = {5'd0, 5'd1}; fwd_data = {32'h0, 32'hBAD};
        #1;
        n_tests++;
        if (stall_req !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall_req: got %b expected 1", stall_req);
        end
        tick();
        n_tests++;
        if (ex_valid !== 1'b0 || stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lu_bubble: valid=%b cnt=%0d expected 0 1", ex_valid, stall_cnt);
        end
        ex_is_load = 0; fwd_en = 2'b10; fwd_addr = {5'd1, 5'd0}; fwd_data = {32'h55, 32'h0};
        #1;
        n_tests++;
        if (stall_req !== 1'b0) begin
            n_fail++; $display("FAIL lu_release: stall_req=%b expected 0", stall_req);
        end
        tick();
        n_tests++;
        if ({ex_valid, ex_src1, ex_src2, ex_alu_op, ex_wr_addr, stall_cnt} !== {1'b1, 32'h55, 32'h1, 8'h26, 5'd4, 4'd1}) begin
            n_fail++; $display("FAIL lu_issue: v=%b s1=%h s2=%h op=%h wa=%0d cnt=%0d", ex_valid, ex_src1, ex_src2, ex_alu_op, ex_wr_addr, stall_cnt);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        in_valid = 1; pc = 32'h800; ins = r_ins(5'd9, 5'd10, 5'd8, 5'd0, 6'h25);
        rf_data1 = 32'hF0; rf_data2 = 32'hF;
        tick();
        stall_in = 1; pc = 32'h900; ins = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h26); rf_data1 = 1; rf_data2 = 2;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({ex_valid, ex_pc, ex_alu_op, ex_src1, ex_src2, ex_wr_addr, stall_req} !== {1'b1, 32'h800, 8'h25, 32'hF0, 32'hF, 5'd8, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: v=%b pc=%h op=%h s1=%h s2=%h wa=%0d sr=%b", c, ex_valid, ex_pc, ex_alu_op, ex_src1, ex_src2, ex_wr_addr, stall_req);
            end
        end
        stall_in = 0; flush = 1;
        tick();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble: valid=%b we=%b expected 0 0", ex_valid, ex_wr_en);
        end
        ins = i_ins(6'h0E, 5'd1, 5'd4, 16'h1); ex_is_load = 1; fwd_en = 2'b01; fwd_addr = {5'd0, 5'd1};
        tick();
        n_tests++;
        if (ex_valid !== 1'b0 || stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL flush_hazard_nocount: valid=%b cnt=%0d expected 0 1", ex_valid, stall_cnt);
        end
        flush = 0;
        repeat (20) tick();
        n_tests++;
        if (stall_cnt !== 4'hF) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d expected 15", stall_cnt);
        end
    endtask

    typedef struct {
        logic [31:0] ins; logic [7:0] op; logic [2:0] sel; logic [31:0] s1, s2;
        logic we, chk_we, ill;
    } dec_t;

    task automatic test_edge_decodes();
        dec_t tbl[9];
        tbl = '{
            '{i_ins(6'h0F, 5'd0, 5'd5, 16'h8001), 8'h25, 3'd1, 32'h80010000, 32'h0, 1'b1, 1'b1, 1'b0},
            '{r_ins(5'd0, 5'd7, 5'd6, 5'd4, 6'h03), 8'h03, 3'd2, 32'h4, 32'h22222222, 1'b1, 1'b1, 1'b0},
            '{{6'h3F, 26'h2BCDEF}, 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1},
            '{32'h0, 8'h7C, 3'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0},
            '{r_ins(5'd0, 5'd0, 5'd0, 5'd0, 6'h0F), 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0},
            '{i_ins(6'h33, 5'd1, 5'd2, 16'h10), 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0},
            '{r_ins(5'd2, 5'd3, 5'd1, 5'd0, 6'h06), 8'h02, 3'd2, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 1'b0},
            '{r_ins(5'd4, 5'd5, 5'd6, 5'd0, 6'h27), 8'h27, 3'd1, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 1'b0},
            '{r_ins(5'd1, 5'd2, 5'd3, 5'd4, 6'h00), 8'h00, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1}
        };
        idle();
        in_valid = 1; rf_data1 = 32'h11111111; rf_data2 = 32'h22222222;
        for (int k = 0; k < 9; k++) begin
            ins = tbl[k].ins;
            tick();
            n_tests++;
            if ({ex_valid, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_illegal} !== {1'b1, tbl[k].op, tbl[k].sel, tbl[k].s1, tbl[k].s2, tbl[k].ill} ||
                (tbl[k].chk_we && ex_wr_en !== tbl[k].we)) begin
                n_fail++; $display("FAIL decode[%0d] ins=%h: v=%b op=%h sel=%0d s1=%h s2=%h we=%b ill=%b; exp op=%h sel=%0d s1=%h s2=%h we=%b ill=%b",
                    k, tbl[k].ins, ex_valid, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_wr_en, ex_illegal,
                    tbl[k].op, tbl[k].sel, tbl[k].s1, tbl[k].s2, tbl[k].we, tbl[k].ill);
            end
        end
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] vf[3];
        logic [5:0] sf[3];
        logic [4:0] ra, rb, rc;
        vf = '{6'h04, 6'h06, 6'h07};
        sf = '{6'h00, 6'h02, 6'h03};
        ra = 5'($urandom_range(0, 3)); rb = 5'($urandom_range(0, 3)); rc = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0: return r_ins(ra, rb, rc, 5'd0, 6'h24 + 6'($urandom_range(0, 3)));
            1: return r_ins(ra, rb, rc, 5'd0, vf[$urandom_range(0, 2)]);
            2: return {11'd0, rb, rc, 5'($urandom), sf[$urandom_range(0, 2)]};
            3: return i_ins(6'h0C + 6'($urandom_range(0, 2)), ra, rb, 16'($urandom));
            4: return i_ins(6'h0F, ra, rb, 16'($urandom));
            5: return {6'd0, 20'($urandom), 6'h0F};
            6: return i_ins(6'h33, ra, rb, 16'($urandom));
            7: return $urandom;
            default: return {6'd0, 20'($urandom), 6'($urandom)};
        endcase
    endfunction

    task automatic test_random();
        ref_t r;
        logic hz;
        logic e_valid, e_we, e_ill;
        logic [31:0] e_pc, e_s1, e_s2;
        logic [7:0] e_op;
        logic [2:0] e_sel;
        logic [4:0] e_wa;
        logic [CNTW-1:0] e_cnt;
        idle();
        reset = 1; #1 reset = 0;
        {e_valid, e_we, e_ill, e_pc, e_s1, e_s2, e_op, e_sel, e_wa, e_cnt} = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0; pc = $urandom; ins = rand_ins();
            rf_data1 = $urandom; rf_data2 = $urandom;
            fwd_en = 2'($urandom_range(0, 3));
            fwd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_data = {32'($urandom), 32'($urandom)};
            ex_is_load = $urandom_range(0, 3) == 0; stall_in = $urandom_range(0, 5) == 0; flush = $urandom_range(0, 7) == 0;
            #1;
            r = ref_decode(ins);
            hz = in_valid && ex_is_load && fwd_en[0] && fwd_addr[4:0] != 0 &&
                 ((r.u1 && fwd_addr[4:0] == ins[25:21]) || (r.u2 && fwd_addr[4:0] == ins[20:16]));
            n_tests++;
            if ({stall_req, rd1_en, rd2_en} !== {hz || stall_in, r.u1, r.u2}) begin
                n_fail++; $display("FAIL rand_comb[%0d] ins=%h: sr/rd1/rd2=%b%b%b expected %b%b%b", c, ins, stall_req, rd1_en, rd2_en, hz || stall_in, r.u1, r.u2);
            end
            if (stall_in) begin
            end else if (flush || !in_valid || hz) begin
                {e_valid, e_we, e_ill, e_pc, e_s1, e_s2, e_op, e_sel, e_wa} = '0;
                if (!flush && hz && e_cnt != 4'hF) e_cnt = e_cnt + 1;
            end else begin
                e_valid = 1; e_pc = pc; e_op = r.op; e_sel = r.sel; e_s1 = r.s1; e_s2 = r.s2;
                e_wa = r.wa; e_we = r.we; e_ill = r.ill;
            end
            tick();
            n_tests++;
            if ({ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_wr_addr, ex_wr_en, ex_illegal, stall_cnt} !==
                {e_valid, e_pc, e_op, e_sel, e_s1, e_s2, e_wa, e_we, e_ill, e_cnt}) begin
                n_fail++; $display("FAIL rand_ex[%0d]: got v=%b pc=%h op=%h sel=%0d s1=%h s2=%h wa=%0d we=%b ill=%b cnt=%0d; exp v=%b pc=%h op=%h sel=%0d s1=%h s2=%h wa=%0d we=%b ill=%b cnt=%0d",
                    c, ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_wr_addr, ex_wr_en, ex_illegal, stall_cnt,
                    e_valid, e_pc, e_op, e_sel, e_s1, e_s2, e_wa, e_we, e_ill, e_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_fwd_priority();
        test_load_use();
        test_stall_flush();
        test_edge_decodes();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
